// File: rtl/snn_csr_bank.sv
// Control/status register bank for the SNN core: shadow/active configuration,
// busy write-lock, W1C interrupt status, decode-error capture and FIFO pop.
module snn_csr_bank #(
  parameter int unsigned NUM_THR     = 4,
  parameter int unsigned OUT_DATA_W  = 4,
  parameter int unsigned CNT_W       = 5,
  parameter logic [31:0] THR_DEFAULT = 32'd200,
  parameter logic [7:0]  TS_DEFAULT  = 8'd8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  input  logic [3:0]              req_wstrb,
  output logic [31:0]             rdata,
  output logic                    rsp_err,
  input  logic                    snn_busy,
  input  logic                    snn_done_pulse,
  input  logic [7:0]              timestep_counter,
  input  logic                    in_fifo_empty,
  input  logic                    in_fifo_full,
  input  logic                    out_fifo_empty,
  input  logic                    out_fifo_full,
  input  logic [OUT_DATA_W-1:0]   out_fifo_rdata,
  input  logic [CNT_W-1:0]        out_fifo_count,
  output logic [NUM_THR*32-1:0]   thresholds,
  output logic [7:0]              timesteps,
  output logic                    reset_mode,
  output logic                    start_pulse,
  output logic                    soft_reset_pulse,
  output logic                    out_fifo_pop,
  output logic                    irq
);

  typedef enum logic [5:0] {
    W_CTRL       = 6'd0,
    W_STATUS     = 6'd1,
    W_TIMESTEPS  = 6'd2,
    W_RESET_MODE = 6'd3,
    W_IRQ_EN     = 6'd4,
    W_IRQ_STAT   = 6'd5,
    W_OUT_DATA   = 6'd6,
    W_OUT_COUNT  = 6'd7,
    W_ERR_ADDR   = 6'd8
  } reg_word_e;

  logic [31:0] thr_shadow [NUM_THR];
  logic [7:0]  ts_shadow;
  logic        rm_shadow;
  logic [2:0]  irq_en;
  logic [2:0]  irq_stat;
  logic [8:0]  err_addr;
  logic        pop_pending;
  logic        full_q;

  logic [5:0]  word;
  logic        thr_hit;
  logic [31:0] thr_idx;
  logic        mapped;
  logic        wr_req;
  logic        rd_req;
  logic        lock_err;
  logic        start_req;
  logic        start_err;
  logic        pop_inflight;
  logic        pop_err;
  logic        pop_accept;
  logic        wr_ok;
  logic        commit;
  logic [2:0]  stat_set;
  logic [2:0]  stat_clr;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:8], req_addr[1:0]};

  assign word    = req_addr[7:2];
  assign thr_idx = {26'd0, word} - 32'd16;
  assign thr_hit = (word[5] | word[4]) && (thr_idx < NUM_THR);
  assign mapped  = (word <= 6'd8) || thr_hit;

  assign wr_req = req_valid & req_write;
  assign rd_req = req_valid & ~req_write;

  assign lock_err     = wr_req & snn_busy &
                        ((word == W_TIMESTEPS) | (word == W_RESET_MODE) | thr_hit);
  assign start_req    = wr_req & (word == W_CTRL) & req_wdata[0];
  assign start_err    = start_req & snn_busy;
  assign pop_inflight = pop_pending | out_fifo_pop;
  assign pop_err      = rd_req & (word == W_OUT_DATA) & pop_inflight;
  assign pop_accept   = rd_req & (word == W_OUT_DATA) & ~out_fifo_empty & ~pop_inflight;

  assign rsp_err  = (req_valid & ~mapped) | lock_err | start_err | pop_err;
  assign wr_ok    = wr_req & ~rsp_err;
  assign commit   = start_req & ~snn_busy;
  assign stat_set = {rsp_err, out_fifo_full & ~full_q, snn_done_pulse};
  assign stat_clr = (wr_req && (word == W_IRQ_STAT)) ? req_wdata[2:0] : '0;

  always_comb begin
    rdata = '0;
    case (word)
      W_STATUS:     rdata = {16'd0, timestep_counter, 2'd0, pop_inflight, out_fifo_full,
                             out_fifo_empty, in_fifo_full, in_fifo_empty, snn_busy};
      W_TIMESTEPS:  rdata = {24'd0, ts_shadow};
      W_RESET_MODE: rdata = {31'd0, rm_shadow};
      W_IRQ_EN:     rdata = {29'd0, irq_en};
      W_IRQ_STAT:   rdata = {29'd0, irq_stat};
      W_OUT_DATA:   if (!out_fifo_empty) rdata = 32'(out_fifo_rdata);
      W_OUT_COUNT:  rdata = 32'(out_fifo_count);
      W_ERR_ADDR:   rdata = {23'd0, err_addr};
      default: begin
        for (int unsigned i = 0; i < NUM_THR; i++) begin
          if (thr_hit && (thr_idx == i)) rdata = thr_shadow[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_THR; i++) thr_shadow[i] <= THR_DEFAULT;
      thresholds       <= {NUM_THR{THR_DEFAULT}};
      ts_shadow        <= TS_DEFAULT;
      timesteps        <= TS_DEFAULT;
      rm_shadow        <= 1'b0;
      reset_mode       <= 1'b0;
      irq_en           <= '0;
      irq_stat         <= '0;
      err_addr         <= '0;
      start_pulse      <= 1'b0;
      soft_reset_pulse <= 1'b0;
      pop_pending      <= 1'b0;
      out_fifo_pop     <= 1'b0;
      full_q           <= 1'b0;
      irq              <= 1'b0;
    end else begin
      start_pulse      <= commit;
      soft_reset_pulse <= wr_req & (word == W_CTRL) & req_wdata[1];
      pop_pending      <= pop_accept;
      out_fifo_pop     <= pop_pending;
      full_q           <= out_fifo_full;
      irq              <= |(irq_stat & irq_en);
      // set is OR-ed after the clear so a coincident event survives the W1C
      irq_stat         <= (irq_stat & ~stat_clr) | stat_set;
      if (rsp_err) err_addr <= {req_write, word, 2'b00};

      if (wr_ok) begin
        if (word == W_TIMESTEPS && req_wstrb[0])  ts_shadow <= req_wdata[7:0];
        if (word == W_RESET_MODE && req_wstrb[0]) rm_shadow <= req_wdata[0];
        if (word == W_IRQ_EN && req_wstrb[0])     irq_en    <= req_wdata[2:0];
        for (int unsigned i = 0; i < NUM_THR; i++) begin
          if (thr_hit && (thr_idx == i)) begin
            for (int unsigned b = 0; b < 4; b++) begin
              if (req_wstrb[b]) thr_shadow[i][8*b +: 8] <= req_wdata[8*b +: 8];
            end
          end
        end
      end

      if (commit) begin
        for (int unsigned i = 0; i < NUM_THR; i++) thresholds[32*i +: 32] <= thr_shadow[i];
        timesteps  <= ts_shadow;
        reset_mode <= rm_shadow;
      end
    end
  end

endmodule

// File: doc/snn_csr_bank.md
# snn_csr_bank

Parametrised control/status register bank for the SNN SoC at base 0x4000_0000, successor to the single-threshold bank. It adds: a per-layer threshold array; shadow/active configuration with commit on START; write-lock while the core is busy; an interrupt controller with W1C status and registered IRQ; decode-error capture; and a parametrised output FIFO data width. It sits between the simplified bus slave (offset addressing) and the SNN subsystem.

## Interface
- NUM_THR, 4: number of layer thresholds (1..16), at 0x40+4*i.
- OUT_DATA_W, 4: output FIFO data width (1..32).
- CNT_W, 5: output FIFO count width.
- THR_DEFAULT, 32'd200: reset value of every threshold.
- TS_DEFAULT, 8'd8: reset value of TIMESTEPS.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid, req_write  in  1  single-cycle bus request; write when req_write=1.
- req_addr  in  32  byte offset; only [7:0] decoded; [1:0] ignored.
- req_wdata  in  32  write data.
- req_wstrb  in  4  byte enables (RW registers only).
- rdata  out  32  combinational read data for current req_addr.
- rsp_err  out  1  combinational; high when the current request is an error (see Operation).
- snn_busy, snn_done_pulse  in  1  core status.
- timestep_counter  in  8  current frame index.
- in_fifo_empty, in_fifo_full, out_fifo_empty, out_fifo_full  in  1  FIFO flags.
- out_fifo_rdata  in  OUT_DATA_W  FIFO head.
- out_fifo_count  in  CNT_W  FIFO occupancy.
- thresholds  out  NUM_THR*32  active thresholds; layer i at [32i+31:32i].
- timesteps  out  8  active timestep count.
- reset_mode  out  1  active reset mode.
- start_pulse, soft_reset_pulse  out  1  single-cycle pulses.
- out_fifo_pop  out  1  single-cycle pop.
- irq  out  1  registered level interrupt.

## Operation
- Register map (offset):
  - 0x00 CTRL: W1P. bit0 START, bit1 SOFT_RESET. Reads 0.
  - 0x04 STATUS: RO. [0] busy, [1] in_empty, [2] in_full, [3] out_empty, [4] out_full, [5] pop_inflight, [15:8] timestep_counter.
  - 0x08 TIMESTEPS: RW shadow [7:0].
  - 0x0C RESET_MODE: RW shadow [0].
  - 0x10 IRQ_EN: RW [2:0].
  - 0x14 IRQ_STAT: W1C [2:0]. [0] DONE, [1] OUT_FULL (rising edge of out_fifo_full), [2] ERR.
  - 0x18 OUT_DATA: RO, zero-extended out_fifo_rdata; reads 0 when empty.
  - 0x1C OUT_COUNT: RO, zero-extended.
  - 0x20 ERR_ADDR: RO, [7:0] offset of last error; [8] was_write.
  - 0x40+4i THR_SHADOW[i]: RW 32-bit with byte strobes, i<NUM_THR.
- Shadow/active: reads return shadow values. A START accepted while snn_busy=0 copies all shadows to the active outputs and asserts start_pulse, both on the same edge. Active values are therefore stable for the whole inference.
- Errors: rsp_err=1 and an error is registered for any of:
  - an access to an unmapped offset (0x24-0x3F, or threshold index ≥NUM_THR);
  - a write to TIMESTEPS, RESET_MODE or THR_SHADOW while snn_busy=1; the write is dropped;
  - a START while snn_busy=1; no pulse and no commit;
  - an OUT_DATA read while pop_inflight; no pop.
  - Each error sets IRQ_STAT[2] and loads ERR_ADDR. Writes to CTRL, IRQ_EN and IRQ_STAT are never locked.
- SOFT_RESET: pulses soft_reset_pulse regardless of busy. It does not alter registers.
- Pop: an OUT_DATA read with !out_fifo_empty and !pop_inflight sets pop_pending. out_fifo_pop follows one cycle later. pop_inflight = pop_pending | out_fifo_pop.
- IRQ: irq <= |(IRQ_STAT & IRQ_EN).

## Timing
- Reset values:
  - thresholds, and every THR_SHADOW: THR_DEFAULT.
  - timesteps, and the TIMESTEPS shadow: TS_DEFAULT.
  - reset_mode: 0.
  - IRQ_EN: 0. IRQ_STAT: 0. ERR_ADDR: 0.
  - start_pulse, soft_reset_pulse, out_fifo_pop, irq: 0.
  - pop_pending: 0.
- Reset mid-operation clears all of the above immediately, including any in-flight pop.
- Write at edge N: the register is visible from N; start_pulse and commit take effect at N; the pulse is high for cycle N..N+1 only.
- Pop latency: read in cycle N; out_fifo_pop is high in cycle N+2.
- Status set/clear precedence: a status event in the same cycle as a W1C of the same bit leaves the bit set (set wins).
- OUT_FULL captures only a 0→1 transition of out_fifo_full, using a 1-cycle registered history (reset 0).
- irq lags IRQ_STAT by one cycle.
- rdata and rsp_err are purely combinational from the request and the current state.

## Test plan
- Reset, then read: THR_SHADOW0 = 200, TIMESTEPS = 8, IRQ_STAT = 0. Outputs: thresholds all 200, irq = 0.
- Write THR_SHADOW1 = 0x0000_0150 with wstrb = 4'b0011 and TIMESTEPS = 16, then START with busy = 0. Required: start_pulse for exactly one cycle; thresholds[63:32] = 0x150 and timesteps = 16 on the same edge.
- busy = 1: write TIMESTEPS = 3. Required: rsp_err = 1; shadow remains 16; IRQ_STAT = 3'b100; ERR_ADDR = 0x108. START in the same state gives no pulse.
- IRQ_EN = 1, then snn_done_pulse. Required: IRQ_STAT[0] = 1 and irq = 1 one cycle later. Then W1C 0x1 in the same cycle as a new done_pulse. Required: IRQ_STAT[0] stays 1.
- FIFO holds 2 entries, rdata = 0x5. Read OUT_DATA at cycle N. Required: rdata = 5 and out_fifo_pop at N+2. A second read at N+1 gives rsp_err = 1 and no extra pop.
- Read offset 0x30. Required: rdata = 0, rsp_err = 1, ERR_ADDR = 0x030. With NUM_THR = 4, a read of 0x50 also errors.
